wb_data_slave: RTL and testbench

Shared Wishbone data-memory slave for the three-core j1_32 cluster. It sits directly downstream of the data-side arbiter and terminates the arbitrated `wb_cyc`/`wb_stb`/`wb_we`/`wb_adr`/`wb_dat_i` bus. It returns `wb_ack` and `wb_dat_o` from one of two spaces:
- a word-addressed RAM;
- a small IO register bank, holding a free-running cycle counter, a scratch register and a test-and-set semaphore for inter-core locking.

---
 rtl/wb_data_slave.sv | 165 ++++++++++++++++
 tb/tb_wb_data_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_data_slave.sv
// wb_data_slave
// Wishbone data-memory slave shared by the three j1_32 cores. It terminates
// the arbitrated bus and answers from one of two spaces:
//   wb_adr[DW-1] = 0 : word-addressed RAM, 2^AW words, index wb_adr[AW-1:0]
//   wb_adr[DW-1] = 1 : IO bank on wb_adr[1:0]
//                      0 CYCLE   free-running counter (writable)
//                      1 SCRATCH plain read/write register
//                      2 SEM     test-and-set semaphore (bit 0)
//                      3 unmapped (reads 0, writes ignored)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wb_cyc, wb_stb    request qualifiers; a request is wb_cyc & wb_stb
//   wb_we             1 = write, 0 = read
//   wb_adr, wb_dat_i  word address and write data
//   wb_ack            one-cycle completion pulse, ack at T+1+WAIT
//   wb_dat_o          read data while wb_ack=1, otherwise 0
module wb_data_slave #(
  parameter int DW   = 32,
  parameter int AW   = 10,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_cyc,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  logic [DW-1:0] wb_adr,
  input  logic [DW-1:0] wb_dat_i,
  output logic          wb_ack,
  output logic [DW-1:0] wb_dat_o
);

  typedef enum logic [1:0] {IDLE, WAITST, ACK} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          io_reg;
  logic [AW-1:0] idx_reg;
  logic [DW-1:0] dat_reg;
  logic          we_reg;
  logic          ack_reg;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  logic [AW-1:0] ram_rd_adr;

  logic [DW-1:0] cycle_cnt;
  logic [DW-1:0] scratch;
  logic          sem;

  logic          req;
  logic          commit;
  logic [DW-1:0] rd_data;

  // Address bits between the RAM index and the space-select bit only alias.
  logic unused_adr_bits;
  assign unused_adr_bits = ^wb_adr[DW-2:AW];

  assign req    = wb_cyc & wb_stb;
  // Writes and the semaphore side-effect land on the edge that ends ACK;
  // a reset arriving in that same cycle discards them.
  assign commit = (state == ACK) && !rst;

  // In IDLE the RAM is addressed straight from the bus so that, even with
  // WAIT=0, the read word is already registered in the ACK cycle. Once a
  // transaction is captured the stored index keeps the read data stable.
  assign ram_rd_adr = (state == IDLE) ? wb_adr[AW-1:0] : idx_reg;

  always_ff @(posedge clk) begin
    if (commit && we_reg && !io_reg) begin
      ram[idx_reg] <= dat_reg;
    end
    ram_q <= ram[ram_rd_adr];
  end

  // Transaction FSM; wb_ack is a registered copy of "in ACK".
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ack_reg  <= 1'b0;
      wait_cnt <= 4'd0;
      io_reg   <= 1'b0;
      idx_reg  <= '0;
      dat_reg  <= '0;
      we_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            io_reg   <= wb_adr[DW-1];
            idx_reg  <= wb_adr[AW-1:0];
            dat_reg  <= wb_dat_i;
            we_reg   <= wb_we;
            wait_cnt <= 4'(WAIT);
            if (WAIT == 0) begin
              state   <= ACK;
              ack_reg <= 1'b1;
            end else begin
              state <= WAITST;
            end
          end
        end
        WAITST: begin
          // A dropped request abandons the transfer with no side-effects.
          if (!req) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd1) begin
            state   <= ACK;
            ack_reg <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK: begin
          state   <= IDLE;
          ack_reg <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ack_reg <= 1'b0;
        end
      endcase
    end
  end

  // IO register bank. CYCLE counts in every state; only rst or a write
  // changes its sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      scratch   <= '0;
      sem       <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (commit && io_reg) begin
        case (idx_reg[1:0])
          2'd0: if (we_reg) cycle_cnt <= dat_reg;
          2'd1: if (we_reg) scratch <= dat_reg;
          // A read of SEM always leaves it set: either it was free and is
          // now taken, or it was already taken.
          2'd2: sem <= we_reg ? dat_reg[0] : 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (io_reg) begin
      case (idx_reg[1:0])
        2'd0:    rd_data = cycle_cnt;
        2'd1:    rd_data = scratch;
        2'd2:    rd_data = {{(DW-1){1'b0}}, sem};
        default: rd_data = '0;
      endcase
    end else begin
      rd_data = ram_q;
    end
  end

  assign wb_ack   = ack_reg;
  assign wb_dat_o = ack_reg ? rd_data : '0;

endmodule

// File: tb/tb_wb_data_slave.sv
// Self-checking bench for wb_data_slave: directed scenarios followed by
// random traffic; a reference model predicts each ack cycle and read value.
module tb_wb_data_slave;
  localparam int DW     = 32;
  localparam int AW     = 10;
  localparam int WAIT   = 3;
  localparam int ACKLAT = WAIT + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic          wb_we = 1'b0;
  logic [DW-1:0] wb_adr = '0;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack;
  logic [DW-1:0] wb_dat_o;

  wb_data_slave #(.DW(DW), .AW(AW), .WAIT(WAIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_i (wb_dat_i),
    .wb_ack   (wb_ack),
    .wb_dat_o (wb_dat_o)
  );

  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc++;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model of the slave's visible state.
  logic [31:0] mem_m [int];
  int          widx[$];
  logic [31:0] scratch_m = 0;
  logic        sem_m = 0;
  logic [31:0] cyc_base = 0;
  int          cyc_base_t = 0;

  function automatic logic [31:0] cycle_at(int n);
    return cyc_base + 32'(n - cyc_base_t);
  endfunction

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          cyc;
    string       nm;
  } exp_t;
  exp_t sb_q[$];

  // Monitor: every acked cycle pops one expectation.
  int last_ack = -10;
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_ack) begin
        if (last_ack == tcyc - 1) begin
          n_cmp++; n_fail++;
          $display("FAIL ack_gap: ack in consecutive cycles %0d and %0d", last_ack, tcyc);
        end
        last_ack = tcyc;
        if (sb_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_ack: ack at cycle %0d with nothing pending, dat_o=%h", tcyc, wb_dat_o);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          n_cmp++;
          if (tcyc != e.cyc) begin
            n_fail++;
            $display("FAIL %s latency: ack at cycle %0d, required %0d", e.nm, tcyc, e.cyc);
          end
          if (e.chk) begin
            n_cmp++;
            if (wb_dat_o !== e.data) begin
              n_fail++;
              $display("FAIL %s data: got %h, required %h", e.nm, wb_dat_o, e.data);
            end else begin
              $display("txn %-10s cyc=%0d dat_o=%h ok", e.nm, tcyc, wb_dat_o);
            end
          end else begin
            $display("txn %-10s cyc=%0d write ack ok", e.nm, tcyc);
          end
        end
      end else begin
        n_cmp++;
        if (wb_dat_o !== '0) begin
          n_fail++;
          $display("FAIL idle_dat: dat_o=%h without ack at cycle %0d, required 0", wb_dat_o, tcyc);
        end
      end
    end
  end

  // One full transfer: predict from the model, push, wait for the ack.
  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat, input string nm);
    exp_t e;
    int   t, a, k;
    int   idx;
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
    t = tcyc;
    a = t + ACKLAT;
    e.data = 0; e.chk = !we; e.cyc = a; e.nm = nm;
    if (!adr[31]) begin
      idx = int'(adr[AW-1:0]);
      if (we) begin
        mem_m[idx] = dat;
        widx.push_back(idx);
      end else begin
        e.data = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        e.chk  = mem_m.exists(idx);
      end
    end else begin
      case (adr[1:0])
        2'd0: if (we) begin cyc_base = dat; cyc_base_t = a + 1; end
              else e.data = cycle_at(a);
        2'd1: if (we) scratch_m = dat; else e.data = scratch_m;
        2'd2: if (we) sem_m = dat[0];
              else begin e.data = {31'b0, sem_m}; sem_m = 1'b1; end
        default: e.data = 0;
      endcase
    end
    sb_q.push_back(e);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wb_ack) break;
    end
    if (k == 40) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: no ack within 40 cycles of cycle %0d", nm, t);
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
  endtask

  // Start a transfer, then drop stb (cyc held) while it waits: no effect.
  task automatic abort_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat);
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
    @(posedge clk); #1;
    wb_stb = 0;
    repeat (5) @(posedge clk);
    #1 wb_cyc = 0; wb_we = 0;
    $display("txn abort     adr=%h we=%0d", adr, we);
  endtask

  task automatic model_reset();
    cyc_base   = 0;
    cyc_base_t = tcyc;
    scratch_m  = 0;
    sem_m      = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old20;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_reset();
    @(negedge clk);
    n_cmp += 2;
    if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b, required 0", wb_ack); end
    if (wb_dat_o !== '0) begin n_fail++; $display("FAIL reset_dat: got %h, required 0", wb_dat_o); end

    // CYCLE read requested at relative cycle 10 after reset.
    while (tcyc - cyc_base_t < 9) @(posedge clk);
    xfer(0, 32'h8000_0000, 0, "cyc_t10");

    // Semaphore from reset.
    xfer(0, 32'h8000_0002, 0, "sem_acq");
    xfer(0, 32'h8000_0002, 0, "sem_busy");
    xfer(1, 32'h8000_0002, 0, "sem_rel");
    xfer(0, 32'h8000_0002, 0, "sem_reacq");
    xfer(0, 32'h8000_0002, 0, "sem_busy2");

    // RAM and aliasing.
    xfer(1, 32'h0000_0005, 32'hDEAD_BEEF, "ram_wr");
    xfer(0, 32'h0000_0005, 0, "ram_rd");
    xfer(1, 32'h0000_0405, 32'h1234_5678, "alias_wr");
    xfer(0, 32'h0000_0005, 0, "alias_rd");
    xfer(1, 32'h8000_0001, 32'hA5A5_A5A5, "scr_wr");
    xfer(0, 32'h8000_0001, 0, "scr_rd");
    xfer(1, 32'h8000_0003, 32'hFFFF_FFFF, "unmap_wr");
    xfer(0, 32'h8000_0003, 0, "unmap_rd");

    // Counter load and wrap through zero.
    xfer(1, 32'h8000_0000, 32'hFFFF_FFFE, "cyc_wr");
    xfer(0, 32'h8000_0000, 0, "cyc_wrap");

    // Aborted RAM write and aborted SEM read.
    abort_xfer(1, 32'h0000_0005, 32'h0BAD_0BAD);
    xfer(0, 32'h0000_0005, 0, "abort_ram");
    xfer(1, 32'h8000_0002, 0, "sem_clr");
    abort_xfer(0, 32'h8000_0002, 0);
    xfer(0, 32'h8000_0002, 0, "abort_sem");
    // stb without cyc must never be accepted.
    @(posedge clk); #1 wb_stb = 1; wb_we = 1; wb_adr = 32'h5; wb_dat_i = 32'h0;
    repeat (4) @(posedge clk);
    #1 wb_stb = 0; wb_we = 0;
    xfer(0, 32'h0000_0005, 0, "stb_only");

    // Reset during a WAITST write to 0x020.
    xfer(1, 32'h0000_0020, 32'h0C0F_FEE0, "pre20_wr");
    old20 = mem_m[32];
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h20; wb_dat_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0;
    model_reset();
    @(negedge clk);
    n_cmp += 2;
    if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %b, required 0", wb_ack); end
    if (wb_dat_o !== '0) begin n_fail++; $display("FAIL rst_mid_dat: got %h, required 0", wb_dat_o); end
    xfer(0, 32'h0000_0020, 0, "rst_ram20");
    n_cmp++;
    if (mem_m[32] !== old20) begin n_fail++; $display("FAIL model20: got %h, required %h", mem_m[32], old20); end
    xfer(0, 32'h8000_0001, 0, "rst_scr");
    xfer(0, 32'h8000_0002, 0, "rst_sem");
    xfer(0, 32'h8000_0000, 0, "rst_cyc");

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      int op;
      logic [31:0] adr, dat;
      op  = $urandom_range(0, 9);
      dat = $urandom;
      if (op <= 3 || widx.size() == 0) begin
        adr = $urandom & 32'h7FFF_FFFF;
        xfer(1, adr, dat, "rnd_ramwr");
      end else if (op <= 5) begin
        adr = ($urandom & 32'h7FFF_FC00) | 32'(widx[$urandom_range(0, widx.size() - 1)]);
        xfer(0, adr, 0, "rnd_ramrd");
      end else begin
        bit we;
        logic [1:0] sel;
        sel = 2'($urandom_range(0, 3));
        we  = ($urandom_range(0, 2) == 0);
        if (sel == 2'd0 && $urandom_range(0, 3) != 0) we = 0;
        adr = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC) | {30'b0, sel};
        xfer(we, adr, dat, "rnd_io");
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
